apb_mbox_completer: RTL and testbench

//  APB3 completer (responder) exposing a TX/RX mailbox: an outbound FIFO fed by APB writes
//  and drained on a valid/ready stream, plus an inbound FIFO filled from a stream and drained
//  by APB reads. Wait states are programmable. Sits behind the APB initiator/bench as a

---
 rtl/apb_mbox_pkg.sv | 46 ++++
 rtl/mbox_sync_fifo.sv | 63 ++++++
 rtl/apb_mbox_completer.sv | 237 +++++++++++++++++++++++
 tb/tb_apb_mbox_completer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mbox_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | apb_mbox_pkg                                                           |
// | Register offsets, APB FSM states and CTRL/STATUS layouts for the       |
// | APB mailbox completer.                                                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package apb_mbox_pkg;

  localparam logic [31:0] c_OFF_CTRL    = 32'h00;
  localparam logic [31:0] c_OFF_STATUS  = 32'h04;
  localparam logic [31:0] c_OFF_TXDATA  = 32'h08;
  localparam logic [31:0] c_OFF_RXDATA  = 32'h0C;
  localparam logic [31:0] c_OFF_WAIT    = 32'h10;
  localparam logic [31:0] c_OFF_SCRATCH = 32'h14;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  typedef struct packed {
    logic ovf_clr;
    logic flush;
    logic en;
  } ctrl_t;

  typedef struct packed {
    logic [14:0] rsvd;
    logic        ovf;
    logic [7:0]  rx_level;
    logic [7:0]  tx_level;
  } status_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mbox_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mbox_sync_fifo                                                         |
// | Show-ahead synchronous FIFO with level output and synchronous flush.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mbox_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [LW-1:0]     level_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              w_do_push;
  logic              w_do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO may accept a push alongside it.
  assign w_do_pop  = pop_i && !empty_o && !flush_i;
  assign w_do_push = push_i && (!full_o || w_do_pop) && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (w_do_push && !w_do_pop)      level_q <= level_q + LW'(1);
      else if (w_do_pop && !w_do_push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/apb_mbox_completer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | apb_mbox_completer                                                     |
// | APB3 completer with TX/RX mailbox FIFOs and programmable wait states.  |
// | Option: APB_MBOX_PSTRB_EN adds PSTRB byte-lane write strobes.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module apb_mbox_completer
  import apb_mbox_pkg::*;
#(
  parameter int          ADDR_W       = 12,
  parameter int          FIFO_DEPTH   = 8,
  parameter int unsigned DEFAULT_WAIT = 0
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
`ifdef APB_MBOX_PSTRB_EN
  input  logic [3:0]  PSTRB,
`endif
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        rx_ready
);

  localparam int          LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] c_ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << ADDR_W) - 32'd1);

  apb_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pready_q, pready_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pslverr_q, pslverr_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] scratch_q, scratch_d;

  logic [3:0]       w_strb;
  logic [31:0]      w_addr;
  logic [31:0]      w_rdata;
  logic             w_err;
  logic             w_commit;
  logic             w_tx_push;
  logic             w_rx_pop;
  logic [7:0]       w_ctrl_byte;
  logic [7:0]       w_wait_byte;
  ctrl_t            w_ctrl_wr;
  status_t          w_status;
  logic [LVL_W-1:0] w_tx_level;
  logic [LVL_W-1:0] w_rx_level;
  logic             w_tx_full, w_tx_empty;
  logic             w_rx_full, w_rx_empty;
  logic [31:0]      w_rx_head;
  logic             w_unused;

`ifdef APB_MBOX_PSTRB_EN
  assign w_strb = PSTRB;
`else
  assign w_strb = 4'hF;
`endif

  assign w_addr      = PADDR & c_ADDR_MASK;
  assign w_ctrl_byte = w_strb[0] ? PWDATA[7:0] : {5'b0, ctrl_q};
  assign w_wait_byte = w_strb[0] ? PWDATA[7:0] : {4'b0, wait_q};
  assign w_ctrl_wr   = ctrl_t'(w_ctrl_byte[2:0]);
  assign w_unused    = ^{PADDR, w_ctrl_byte[7:3], w_wait_byte[7:4]};

  assign PREADY   = pready_q;
  assign PRDATA   = prdata_q;
  assign PSLVERR  = pslverr_q;
  assign tx_valid = !w_tx_empty;
  assign rx_ready = !w_rx_full && ctrl_q.en;

  // Read data and error are decoded live; the FSM captures them on the edge PREADY rises.
  always_comb begin
    w_err    = 1'b0;
    w_rdata  = '0;
    w_status = '0;
    w_status.ovf      = ovf_q;
    w_status.rx_level = 8'(w_rx_level);
    w_status.tx_level = 8'(w_tx_level);
    case (w_addr)
      c_OFF_CTRL:    w_rdata = 32'(ctrl_q);
      c_OFF_STATUS:  begin w_err = PWRITE; w_rdata = w_status; end
      c_OFF_TXDATA:  w_err = !PWRITE || w_tx_full || (w_strb != 4'hF);
      c_OFF_RXDATA:  begin w_err = PWRITE || w_rx_empty; w_rdata = w_rx_head; end
      c_OFF_WAIT:    w_rdata = 32'(wait_q);
      c_OFF_SCRATCH: w_rdata = scratch_q;
      default:       w_err = 1'b1;
    endcase
    if (PWRITE || w_err) w_rdata = '0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    w_commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ST_ACCESS;
          cnt_d    = wait_q;
          pready_d = (wait_q == 4'd0);
          if (wait_q == 4'd0) begin
            prdata_d  = w_rdata;
            pslverr_d = w_err;
          end
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          state_d   = ST_IDLE;
          cnt_d     = 4'd0;
          pready_d  = 1'b0;
          prdata_d  = '0;
          pslverr_d = 1'b0;
        end else if (!pready_q) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            prdata_d  = w_rdata;
            pslverr_d = w_err;
          end
        end else if (PENABLE) begin
          w_commit  = 1'b1;
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          prdata_d  = '0;
          pslverr_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d         = ctrl_q;
    ctrl_d.flush   = 1'b0;
    ctrl_d.ovf_clr = 1'b0;
    ovf_d          = ovf_q;
    wait_d         = wait_q;
    scratch_d      = scratch_q;
    w_tx_push      = 1'b0;
    w_rx_pop       = 1'b0;
    if (w_commit && !pslverr_q) begin
      if (PWRITE) begin
        case (w_addr)
          c_OFF_CTRL: begin
            ctrl_d.en    = w_ctrl_wr.en;
            ctrl_d.flush = w_ctrl_wr.flush;
            if (w_ctrl_wr.ovf_clr) ovf_d = 1'b0;
          end
          c_OFF_TXDATA:  w_tx_push = 1'b1;
          c_OFF_WAIT:    wait_d    = w_wait_byte[3:0];
          c_OFF_SCRATCH: scratch_d = byte_merge(scratch_q, PWDATA, w_strb);
          default: ;
        endcase
      end else if (w_addr == c_OFF_RXDATA) begin
        w_rx_pop = 1'b1;
      end
    end
    if (rx_valid && w_rx_full && ctrl_q.en) ovf_d = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      ctrl_q    <= '0;
      ovf_q     <= 1'b0;
      wait_q    <= 4'(DEFAULT_WAIT);
      scratch_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      ctrl_q    <= ctrl_d;
      ovf_q     <= ovf_d;
      wait_q    <= wait_d;
      scratch_q <= scratch_d;
    end
  end

  mbox_sync_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk         (PCLK),
    .rst_n       (PRESETn),
    .flush_i     (ctrl_q.flush),
    .push_i      (w_tx_push),
    .push_data_i (PWDATA),
    .pop_i       (tx_valid && tx_ready),
    .head_o      (tx_data),
    .level_o     (w_tx_level),
    .full_o      (w_tx_full),
    .empty_o     (w_tx_empty)
  );

  mbox_sync_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk         (PCLK),
    .rst_n       (PRESETn),
    .flush_i     (ctrl_q.flush),
    .push_i      (rx_valid && rx_ready),
    .push_data_i (rx_data),
    .pop_i       (w_rx_pop),
    .head_o      (w_rx_head),
    .level_o     (w_rx_level),
    .full_o      (w_rx_full),
    .empty_o     (w_rx_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_apb_mbox_completer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_apb_mbox_completer                                                  |
// | Scoreboard bench: APB driver queues expected responses, monitors check.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_apb_mbox_completer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_ready;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tx_exp_q[$];

  always #5 PCLK = ~PCLK;

  apb_mbox_completer #(
    .ADDR_W       (12),
    .FIFO_DEPTH   (8),
    .DEFAULT_WAIT (0)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
`ifdef APB_MBOX_PSTRB_EN
    .PSTRB    (4'hF),
`endif
    .PREADY   (PREADY),
    .PRDATA   (PRDATA),
    .PSLVERR  (PSLVERR),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // APB monitor: one completion per transfer, checked against the queued expectation.
  always @(negedge PCLK) begin
    exp_t e;
    if (PRESETn && PSEL && PENABLE && PREADY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_pslverr"}, {31'b0, PSLVERR}, {31'b0, e.err});
        if (e.is_read) chk({e.name, "_prdata"}, PRDATA, e.rdata);
      end
    end
  end

  // Outbound stream monitor.
  always @(negedge PCLK) begin
    logic [31:0] w;
    if (PRESETn && tx_valid && tx_ready) begin
      if (tx_exp_q.size() == 0) begin
        chk("tx_unexpected", tx_data, 32'd0);
      end else begin
        w = tx_exp_q.pop_front();
        chk("tx_word", tx_data, w);
      end
    end
  end

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err, input string name,
                     output int waits);
    exp_t e;
    bit   done;
    int   k;
    e.is_read = !wr;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.name    = name;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0; done = 1'b0; k = 0;
    while (!done && k < 40) begin
      @(negedge PCLK);
      if (PREADY) done = 1'b1;
      else waits++;
      k++;
    end
    if (!done) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    bit done;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pready", {31'b0, PREADY}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    apb(1'b1, 32'h14, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr_scratch", w);
    chk("wr_scratch_waits", w, 32'd0);
    apb(1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd_scratch", w);
    chk("rd_scratch_waits", w, 32'd0);
    apb(1'b0, 32'h00, 32'h0, 32'h0, 1'b0, "rd_ctrl_rst", w);

    apb(1'b1, 32'h10, 32'h3, 32'h0, 1'b0, "wr_wait3", w);
    apb(1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd_scratch_w3", w);
    chk("wait3_cycles", w, 32'd3);
    apb(1'b0, 32'h10, 32'h0, 32'h3, 1'b0, "rd_wait", w);
    apb(1'b1, 32'h10, 32'h0, 32'h0, 1'b0, "wr_wait0", w);

    apb(1'b0, 32'h100, 32'h0, 32'h0, 1'b1, "rd_unmapped", w);
    apb(1'b0, 32'h0C, 32'h0, 32'h0, 1'b1, "rd_rx_empty", w);
    apb(1'b1, 32'h04, 32'h1234, 32'h0, 1'b1, "wr_status", w);
    apb(1'b0, 32'h08, 32'h0, 32'h0, 1'b1, "rd_txdata", w);
    apb(1'b1, 32'h16, 32'h1, 32'h0, 1'b1, "wr_misaligned", w);

    apb(1'b1, 32'h00, 32'h1, 32'h0, 1'b0, "wr_ctrl_en", w);
    apb(1'b0, 32'h00, 32'h0, 32'h1, 1'b0, "rd_ctrl_en", w);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_exp_q.push_back(32'hA000_0000 + i);
      apb(1'b1, 32'h08, 32'hA000_0000 + i, 32'h0, (i == 8), "wr_tx", w);
    end
    apb(1'b0, 32'h04, 32'h0, 32'h0000_0008, 1'b0, "status_tx_full", w);
    tx_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge PCLK);
      if (tx_exp_q.size() == 0) done = 1'b1;
    end
    chk("tx_drain_left", tx_exp_q.size(), 32'd0);
    @(posedge PCLK); #1;
    tx_ready = 1'b0;
    tx_exp_q.delete();

    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 32'hB000_0000 + i;
      @(posedge PCLK); #1;
    end
    rx_valid = 1'b0;
    @(negedge PCLK);
    chk("rx_ready_full", {31'b0, rx_ready}, 32'd0);
    apb(1'b0, 32'h04, 32'h0, 32'h0001_0800, 1'b0, "status_ovf", w);
    for (int i = 0; i < 8; i++) begin
      apb(1'b0, 32'h0C, 32'h0, 32'hB000_0000 + i, 1'b0, "rd_rx", w);
    end
    apb(1'b0, 32'h0C, 32'h0, 32'h0, 1'b1, "rd_rx_drained", w);
    apb(1'b1, 32'h00, 32'h5, 32'h0, 1'b0, "wr_ctrl_ovfclr", w);
    apb(1'b0, 32'h04, 32'h0, 32'h0, 1'b0, "status_cleared", w);

    apb(1'b1, 32'h08, 32'hC000_0001, 32'h0, 1'b0, "wr_tx_f1", w);
    apb(1'b1, 32'h08, 32'hC000_0002, 32'h0, 1'b0, "wr_tx_f2", w);
    rx_valid = 1'b1; rx_data = 32'hC0DE_0001;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
    apb(1'b0, 32'h04, 32'h0, 32'h0000_0102, 1'b0, "status_preflush", w);
    apb(1'b1, 32'h00, 32'h3, 32'h0, 1'b0, "wr_ctrl_flush", w);
    apb(1'b0, 32'h04, 32'h0, 32'h0, 1'b0, "status_flushed", w);
    apb(1'b0, 32'h00, 32'h0, 32'h1, 1'b0, "rd_ctrl_selfclr", w);

    apb(1'b1, 32'h10, 32'h5, 32'h0, 1'b0, "wr_wait5", w);
    apb(1'b1, 32'h08, 32'hE000_0001, 32'h0, 1'b0, "wr_tx_w5", w);
    chk("wait5_cycles", w, 32'd5);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h14;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #2;
    chk("midrst_pready", {31'b0, PREADY}, 32'd0);
    chk("midrst_tx_valid", {31'b0, tx_valid}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    apb(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, "rd_wait_after_rst", w);
    chk("after_rst_waits", w, 32'd0);
    apb(1'b0, 32'h04, 32'h0, 32'h0, 1'b0, "status_after_rst", w);
    apb(1'b0, 32'h00, 32'h0, 32'h0, 1'b0, "ctrl_after_rst", w);

    repeat (2) @(posedge PCLK);
    chk("scoreboard_left", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
